// File: rtl/apb_pkg.sv
// Shared APB3 definitions: initiator state encoding, bus constants and parameter helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic        APB_WRITE   = 1'b1;
    localparam logic        APB_READ    = 1'b0;
    localparam int unsigned APB_TIMER_W = 16;
    localparam int unsigned APB_MAX_WAIT = 65535;

    // APB3 data buses are 8, 16 or 32 bits wide
    function automatic bit apb_data_width_ok(input int unsigned w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/apb3_initiator_if.sv
// Request/response handshake plus APB3 bus, viewed from the initiator (master) or its environment (slave).
interface apb3_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts APB ACCESS wait cycles and flags the cycle on which the wait budget is used up.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expired_c
);

    logic [APB_TIMER_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + APB_TIMER_W'(1);
        end
    end

    // fires on the MAX_WAIT-th wait cycle so the response follows on the next edge
    assign expired_c = count_en && (cnt_q == APB_TIMER_W'(MAX_WAIT - 1));

endmodule

// File: rtl/apb3_initiator.sv
// APB3 initiator: turns a valid/ready request into an IDLE/SETUP/ACCESS transfer with a one-cycle response.
// Optional ACCESS wait timeout is built when APB3_INITIATOR_TIMEOUT_EN is defined.
module apb3_initiator
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    apb3_initiator_if.master bus
);

    if (!apb_data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
        $error("apb3_initiator: DATA_WIDTH must be 8, 16 or 32");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > APB_MAX_WAIT)) begin : g_bad_timeout
        $error("apb3_initiator: TIMEOUT_CYCLES must be in 1..65535");
    end

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic                  pwrite_d;
    logic                  psel_d;
    logic                  penable_d;
    logic                  req_ready_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d;
    logic                  accept_c;
    logic                  xfer_done_c;

    assign accept_c    = bus.req_valid && bus.req_ready;
    // completer response is only meaningful in a selected, enabled, ready cycle
    assign xfer_done_c = bus.PSEL && bus.PENABLE && bus.PREADY;

`ifdef APB3_INITIATOR_TIMEOUT_EN
    logic timeout_c;
    logic wait_c;
    logic wait_clear_c;
    logic rsp_timeout_d;

    assign wait_c       = (state_q == ACCESS) && !bus.PREADY;
    assign wait_clear_c = (state_q != ACCESS);

    apb_wait_timer #(
        .MAX_WAIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst_n     (PRESETN),
        .count_en  (wait_c),
        .clear     (wait_clear_c),
        .expired_c (timeout_c)
    );
`endif

    // next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        paddr_d     = bus.PADDR;
        pwdata_d    = bus.PWDATA;
        pwrite_d    = bus.PWRITE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = bus.rsp_rdata;
        rsp_err_d   = bus.rsp_err;
`ifdef APB3_INITIATOR_TIMEOUT_EN
        rsp_timeout_d = bus.rsp_timeout;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d  = SETUP;
                    paddr_d  = bus.req_addr;
                    pwdata_d = bus.req_wdata;
                    pwrite_d = bus.req_write;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (xfer_done_c) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (bus.PWRITE == APB_WRITE) ? '0 : bus.PRDATA;
                    rsp_err_d   = bus.PSLVERR;
`ifdef APB3_INITIATOR_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (timeout_c) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= IDLE;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.PWRITE    <= APB_READ;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.PADDR     <= paddr_d;
            bus.PWDATA    <= pwdata_d;
            bus.PWRITE    <= pwrite_d;
            bus.PSEL      <= psel_d;
            bus.PENABLE   <= penable_d;
            bus.req_ready <= req_ready_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_rdata <= rsp_rdata_d;
            bus.rsp_err   <= rsp_err_d;
        end
    end

`ifdef APB3_INITIATOR_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.rsp_timeout <= rsp_timeout_d;
        end
    end
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb3_initiator.sv
// Directed bench for apb3_initiator: vector table of single transfers plus back-to-back, wait/timeout and reset sequences.
module tb_apb3_initiator;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    apb3_initiator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb3_initiator #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK    (clk),
        .PRESETN (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        pslverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one request through the DUT; completer inserts v.waits wait states and garbage outside real responses
    task automatic run_vec(input int id, input vec_t v);
        int cyc;
        int waits_left;
        bit got;
        check($sformatf("v%0d_ready_before", id), 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = v.write;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        step();
        bus.req_valid = 1'b0;
        bus.req_write = ~v.write;
        bus.req_addr  = ~v.addr;
        bus.req_wdata = ~v.wdata;
        check($sformatf("v%0d_setup_psel", id), 32'(bus.PSEL), 32'd1);
        check($sformatf("v%0d_setup_penable", id), 32'(bus.PENABLE), 32'd0);
        check($sformatf("v%0d_setup_ready", id), 32'(bus.req_ready), 32'd0);
        cyc = 1;
        waits_left = v.waits;
        got = 1'b0;
        while (!got && cyc < 64) begin
            if (bus.PSEL && bus.PENABLE) begin
                check($sformatf("v%0d_c%0d_paddr", id, cyc), 32'(bus.PADDR), 32'(v.addr));
                check($sformatf("v%0d_c%0d_pwrite", id, cyc), 32'(bus.PWRITE), 32'(v.write));
                check($sformatf("v%0d_c%0d_pwdata", id, cyc), bus.PWDATA, v.wdata);
                if (waits_left > 0) begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = $urandom;
                    bus.PSLVERR = 1'b1;
                    waits_left--;
                end else begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = v.prdata;
                    bus.PSLVERR = v.pslverr;
                end
            end else begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'b1;
            end
            step();
            cyc++;
            got = bus.rsp_valid;
        end
        check($sformatf("v%0d_rsp_seen", id), 32'(got), 32'd1);
        check($sformatf("v%0d_latency", id), 32'(cyc), 32'(v.exp_lat));
        check($sformatf("v%0d_rdata", id), bus.rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", id), 32'(bus.rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d_timeout", id), 32'(bus.rsp_timeout), 32'd0);
        check($sformatf("v%0d_idle_ready", id), 32'(bus.req_ready), 32'd1);
        check($sformatf("v%0d_idle_psel", id), 32'(bus.PSEL), 32'd0);
        bus.PREADY = 1'b0;
        step();
        check($sformatf("v%0d_pulse_len", id), 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vecs[0] = '{1'b1, 8'hA0, 32'h0000_0003, 0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 3};
        vecs[1] = '{1'b0, 8'h90, 32'h1111_2222, 4, 32'h0000_0002, 1'b0, 32'h0000_0002, 1'b0, 7};
        vecs[2] = '{1'b0, 8'h44, 32'h0000_0000, 0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 3};
        vecs[3] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 1, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b1, 4};
        vecs[4] = '{1'b0, 8'h00, 32'h5555_AAAA, 2, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 1'b0, 5};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 32'h0;
        bus.PRDATA    = 32'h0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // reset values
        step();
        step();
        check("rst_psel", 32'(bus.PSEL), 32'd0);
        check("rst_penable", 32'(bus.PENABLE), 32'd0);
        check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        check("rst_paddr", 32'(bus.PADDR), 32'd0);
        check("rst_pwdata", bus.PWDATA, 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", 32'(bus.req_ready), 32'd0);
        step();
        check("rel_ready_first_edge", 32'(bus.req_ready), 32'd1);

        // table of single transfers
        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // back-to-back requests with req_valid held high and PREADY tied high
        begin : b2b
            int idx;
            int acc_cyc[3];
            int rsp_cnt;
            int bad_enable;
            bit prev_setup;
            bit prev_penable;
            bit will_accept;
            idx = 0;
            rsp_cnt = 0;
            bad_enable = 0;
            prev_setup = 1'b0;
            prev_penable = 1'b0;
            acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
            bus.PREADY    = 1'b1;
            bus.PSLVERR   = 1'b0;
            bus.PRDATA    = 32'h0BAD_0BAD;
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = 8'h10;
            bus.req_wdata = 32'h0000_0010;
            for (int c = 0; c < 16; c++) begin
                will_accept = bus.req_valid && bus.req_ready;
                prev_setup = bus.PSEL && !bus.PENABLE;
                prev_penable = bus.PENABLE;
                step();
                if (bus.PENABLE && !prev_penable && !prev_setup) bad_enable++;
                if (bus.rsp_valid) rsp_cnt++;
                if (will_accept) begin
                    acc_cyc[idx] = c;
                    idx++;
                    if (idx < 3) begin
                        bus.req_addr  = 8'(8'h10 + 8'(idx));
                        bus.req_wdata = 32'(32'h10 + 32'(idx));
                    end else begin
                        bus.req_valid = 1'b0;
                    end
                end
            end
            check("b2b_accepted", 32'(idx), 32'd3);
            check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            check("b2b_rsp_count", 32'(rsp_cnt), 32'd3);
            check("b2b_penable_no_setup", 32'(bad_enable), 32'd0);
            check("b2b_last_paddr", 32'(bus.PADDR), 32'h12);
            check("b2b_last_pwdata", bus.PWDATA, 32'h12);
        end

        // completer never ready: timeout when built in, indefinite wait otherwise
        begin : stall
            int cyc;
            bit got;
            bus.PREADY    = 1'b0;
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = 8'h3C;
            bus.req_wdata = 32'h0;
            check("stall_ready_before", 32'(bus.req_ready), 32'd1);
            step();
            bus.req_valid = 1'b0;
            cyc = 1;
            got = 1'b0;
            while (!got && cyc < 24) begin
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'b1;
                step();
                cyc++;
                got = bus.rsp_valid;
            end
`ifdef APB3_INITIATOR_TIMEOUT_EN
            check("to_rsp_seen", 32'(got), 32'd1);
            check("to_latency", 32'(cyc), 32'd10);
            check("to_err", 32'(bus.rsp_err), 32'd1);
            check("to_timeout", 32'(bus.rsp_timeout), 32'd1);
            check("to_rdata", bus.rsp_rdata, 32'd0);
            check("to_idle_ready", 32'(bus.req_ready), 32'd1);
            check("to_idle_psel", 32'(bus.PSEL), 32'd0);
            step();
            check("to_pulse_len", 32'(bus.rsp_valid), 32'd0);
`else
            check("nto_no_rsp", 32'(got), 32'd0);
            check("nto_still_access", 32'(bus.PSEL && bus.PENABLE), 32'd1);
            check("nto_timeout_low", 32'(bus.rsp_timeout), 32'd0);
            bus.PREADY  = 1'b1;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = 32'h0000_0007;
            step();
            bus.PREADY = 1'b0;
            check("nto_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("nto_rdata", bus.rsp_rdata, 32'h7);
            check("nto_err", 32'(bus.rsp_err), 32'd0);
            check("nto_timeout", 32'(bus.rsp_timeout), 32'd0);
            step();
            check("nto_pulse_len", 32'(bus.rsp_valid), 32'd0);
`endif
        end

        // reset pulsed during ACCESS aborts the transfer
        begin : abort
            int rsp_cnt;
            rsp_cnt = 0;
            bus.PREADY    = 1'b0;
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = 8'h77;
            bus.req_wdata = 32'h7777_7777;
            step();
            bus.req_valid = 1'b0;
            step();
            check("abort_in_access", 32'(bus.PSEL && bus.PENABLE), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check("abort_psel", 32'(bus.PSEL), 32'd0);
            check("abort_penable", 32'(bus.PENABLE), 32'd0);
            check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("abort_ready", 32'(bus.req_ready), 32'd0);
            check("abort_paddr", 32'(bus.PADDR), 32'd0);
            bus.PREADY = 1'b1;
            step();
            @(negedge clk);
            rst_n = 1'b1;
            step();
            check("abort_ready_first_edge", 32'(bus.req_ready), 32'd1);
            check("abort_psel_after", 32'(bus.PSEL), 32'd0);
            for (int c = 0; c < 3; c++) begin
                if (bus.rsp_valid) rsp_cnt++;
                step();
            end
            check("abort_no_rsp", 32'(rsp_cnt), 32'd0);
        end

        // normal transfer after the abort
        run_vec(5, vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
